afu_write_drain: RTL and testbench
==================================

Name: afu_write_drain

Overview:
- Downstream stage of the user AFU. Drains the 512-bit output FIFO, one cache line per entry.
- Issues each line as a write request on the CCI-style TX write channel to consecutive cache-line addresses starting at dst_addr.
- Counts write responses and raises done once ctx_length lines are acknowledged.

Parameters:
ADDR_WIDTH, 32, cache-line address width
TAG_WIDTH, 14, write-request tag width
MAX_OUTSTANDING, 32, max write requests issued but not yet acknowledged (power of two, at most 2**TAG_WIDTH)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a context
ctx_length  input  32  number of lines to write; sampled on start
dst_addr  input  ADDR_WIDTH  base cache-line address; sampled on start
output_fifo_dout  input  512  FIFO read data, valid the cycle after output_fifo_re
output_fifo_empty  input  1  FIFO empty
output_fifo_re  output  1  FIFO read enable
tx_wr_almostfull  input  1  TX write channel backpressure
tx_wr_valid  output  1  write request valid
tx_wr_addr  output  ADDR_WIDTH  write address
tx_wr_tag  output  TAG_WIDTH  write tag
tx_wr_data  output  512  write data
rx_wr_valid  input  1  one write response
busy  output  1  context in progress
done  output  1  held high from completion until next start

Behaviour:
- Reset values: every output and register is 0. State is IDLE.
- State IDLE:
  - start latches ctx_length into len_r and dst_addr into base_r.
  - All counters clear.
  - If len_r is 0, go to DONE; otherwise go to RUN.
- State RUN, read rule: output_fifo_re = !output_fifo_empty && !tx_wr_almostfull && rd_cnt < len_r && outstanding < MAX_OUTSTANDING.
- State RUN, issue rule:
  - One cycle after a read, assert tx_wr_valid for exactly one cycle.
  - tx_wr_data = output_fifo_dout.
  - tx_wr_addr = base_r + wr_cnt, truncated to ADDR_WIDTH; wrap-around is allowed.
  - tx_wr_tag = wr_cnt[TAG_WIDTH-1:0].
  - wr_cnt then increments.
- State RUN, exit: when wr_cnt == len_r, go to DRAIN.
- Throughput: one line per cycle when not stalled. Read-to-request latency is 1 cycle.
- No skid buffer. A request issued in the cycle almostfull rises is legal, because the channel guarantees slack.
- State DRAIN: wait until ack_cnt == len_r, then go to DONE.
- State DONE: done = 1. A new start re-enters IDLE behaviour in the same cycle.
- Outstanding count:
  - Each accepted read increments outstanding (counted at read time); each rx_wr_valid decrements it.
  - A read and a response in the same cycle leave it unchanged.
- Responses: rx_wr_valid increments ack_cnt in any state except IDLE. Responses arriving in IDLE are ignored.
- busy = (state == RUN || state == DRAIN).
- start while busy is ignored.
- Reset asserted mid-context: asynchronous return to IDLE, tx_wr_valid drops immediately, and the partial context is discarded.
- Arithmetic: all counters are 32-bit unsigned; outstanding is clog2(MAX_OUTSTANDING)+1 bits.

Optional Feature:
- Macro: WR_DRAIN_PERF_EN.
- When defined:
  - Adds output stall_cycles (32 bits) and output run_cycles (32 bits), both cleared on start.
  - run_cycles increments every cycle in RUN or DRAIN.
  - stall_cycles increments every RUN cycle where the FIFO is non-empty, rd_cnt < len_r, and the read is blocked by tx_wr_almostfull or the outstanding limit.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: neither port nor its logic exists.

Test Plan:
- ctx_length=4, dst_addr=0x1000, FIFO preloaded with 4 lines, no backpressure, response 5 cycles after each request:
  - requests issue on 4 consecutive cycles with addresses 0x1000–0x1003 and tags 0–3;
  - done rises 1 cycle after the 4th response.
- ctx_length=0 start -> done=1 on the next cycle, no tx_wr_valid, busy never asserted.
- ctx_length=8, tx_wr_almostfull held high for cycles 2–6 -> no output_fifo_re while high; all 8 writes complete in order with data matching FIFO order.
- MAX_OUTSTANDING=4, ctx_length=10, responses withheld -> exactly 4 requests then stall; releasing one response lets exactly one more request issue.
- dst_addr=0xFFFFFFFE, ctx_length=3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Reset asserted after 2 of 6 writes -> outputs go to 0 immediately; a new start with ctx_length=2 completes normally with counters restarted from 0.

Source files
------------

// File: rtl/afu_write_drain.sv
// rtl/afu_write_drain.sv - drains 512-bit output FIFO lines into CCI-style TX write requests
// Optional WR_DRAIN_PERF_EN adds stall_cycles/run_cycles performance counters.
module afu_write_drain #(
    parameter int ADDR_WIDTH      = 32,
    parameter int TAG_WIDTH       = 14,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           ctx_length,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [511:0]          output_fifo_dout,
    input  logic                  output_fifo_empty,
    output logic                  output_fifo_re,
    input  logic                  tx_wr_almostfull,
    output logic                  tx_wr_valid,
    output logic [ADDR_WIDTH-1:0] tx_wr_addr,
    output logic [TAG_WIDTH-1:0]  tx_wr_tag,
    output logic [511:0]          tx_wr_data,
    input  logic                  rx_wr_valid,
    output logic                  busy,
    output logic                  done
`ifdef WR_DRAIN_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           run_cycles
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [31:0]           len_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [31:0]           rd_cnt;
    logic [31:0]           wr_cnt;
    logic [31:0]           ack_cnt;
    logic [OUT_W-1:0]      outstanding;

    logic                  have_work;
    logic                  rd_ok;
    logic                  ack_en;
    logic                  out_dec;
    logic                  start_ok;
    logic [31:0]           ack_next;

    assign have_work      = !output_fifo_empty && (rd_cnt < len_r);
    assign rd_ok          = (state == S_RUN) && have_work && !tx_wr_almostfull
                            && (outstanding < MAX_OUT);
    assign output_fifo_re = rd_ok;
    assign ack_en         = rx_wr_valid && (state != S_IDLE);
    assign out_dec        = ack_en && (outstanding != '0);
    assign ack_next       = ack_cnt + {31'b0, ack_en};
    assign start_ok       = start && ((state == S_IDLE) || (state == S_DONE));

    // FIFO data arrives the cycle after the read, so the request is issued straight from dout.
    assign tx_wr_addr = tx_wr_valid ? (base_r + ADDR_WIDTH'(wr_cnt)) : '0;
    assign tx_wr_tag  = tx_wr_valid ? wr_cnt[TAG_WIDTH-1:0] : '0;
    assign tx_wr_data = tx_wr_valid ? output_fifo_dout : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            len_r       <= '0;
            base_r      <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            ack_cnt     <= '0;
            outstanding <= '0;
            tx_wr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            tx_wr_valid <= rd_ok;
            ack_cnt     <= ack_next;
            if (rd_ok) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (tx_wr_valid) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (rd_ok && !out_dec) begin
                outstanding <= outstanding + 1'b1;
            end else if (!rd_ok && out_dec) begin
                outstanding <= outstanding - 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        len_r       <= ctx_length;
                        base_r      <= dst_addr;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        ack_cnt     <= '0;
                        outstanding <= '0;
                        if (ctx_length == 32'd0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Last response may already be arriving as the final request retires.
                    if (wr_cnt == len_r) begin
                        if (ack_next >= len_r) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ack_next >= len_r) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WR_DRAIN_PERF_EN
    logic stall_now;

    assign stall_now = (state == S_RUN) && have_work
                       && (tx_wr_almostfull || (outstanding >= MAX_OUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            run_cycles   <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
            run_cycles   <= '0;
        end else begin
            if (busy && (run_cycles != 32'hFFFF_FFFF)) begin
                run_cycles <= run_cycles + 32'd1;
            end
            if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_afu_write_drain.sv
// tb/tb_afu_write_drain.sv - scoreboard bench for afu_write_drain
module tb_afu_write_drain;

    localparam int AW = 32;
    localparam int TW = 14;
    localparam int MO = 4;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [TW-1:0]  tag;
        logic [511:0]   data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   ctx_length = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [511:0]  output_fifo_dout = '0;
    logic          output_fifo_empty;
    logic          output_fifo_re;
    logic          tx_wr_almostfull = 1'b0;
    logic          tx_wr_valid;
    logic [AW-1:0] tx_wr_addr;
    logic [TW-1:0] tx_wr_tag;
    logic [511:0]  tx_wr_data;
    logic          rx_wr_valid;
    logic          busy;
    logic          done;
`ifdef WR_DRAIN_PERF_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   run_cycles;
`endif

    exp_t          sb[$];
    logic [511:0]  fifo_mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            n_req = 0;
    int            last_rx_cyc = 0;
    int            req_cyc [0:63];
    logic          auto_resp = 1'b1;
    logic          rx_manual = 1'b0;
    logic [4:0]    resp_pipe = '0;

    afu_write_drain #(
        .ADDR_WIDTH      (AW),
        .TAG_WIDTH       (TW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .ctx_length        (ctx_length),
        .dst_addr          (dst_addr),
        .output_fifo_dout  (output_fifo_dout),
        .output_fifo_empty (output_fifo_empty),
        .output_fifo_re    (output_fifo_re),
        .tx_wr_almostfull  (tx_wr_almostfull),
        .tx_wr_valid       (tx_wr_valid),
        .tx_wr_addr        (tx_wr_addr),
        .tx_wr_tag         (tx_wr_tag),
        .tx_wr_data        (tx_wr_data),
        .rx_wr_valid       (rx_wr_valid),
        .busy              (busy),
        .done              (done)
`ifdef WR_DRAIN_PERF_EN
        ,
        .stall_cycles      (stall_cycles),
        .run_cycles        (run_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign output_fifo_empty = (rd_ptr == wr_ptr);
    assign rx_wr_valid       = resp_pipe[4] | rx_manual;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        resp_pipe <= {resp_pipe[3:0], tx_wr_valid & auto_resp};
        if (output_fifo_re) begin
            output_fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (tx_wr_valid) begin
            if (n_req < 64) req_cyc[n_req] = cyc;
            n_req++;
            check_val("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val("req_addr", tx_wr_addr, e.addr);
                check_val("req_tag", tx_wr_tag, e.tag);
                check_val("req_data", tx_wr_data, e.data);
            end
        end
        if (rx_wr_valid) last_rx_cyc = cyc;
    end

    task automatic load_ctx(input int n, input logic [AW-1:0] base);
        exp_t e;
        logic [511:0] d;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
            fifo_mem[wr_ptr] = d;
            wr_ptr++;
            e.addr = base + AW'(i);
            e.tag  = TW'(i);
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic start_ctx(input logic [31:0] len, input logic [AW-1:0] addr);
        @(negedge clk);
        ctx_length = len;
        dst_addr   = addr;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim, output int dc);
        dc = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                dc = cyc;
                break;
            end
        end
        check_val({tag, "_done"}, done, 1);
    endtask

    initial begin
        int n0;
        int dc;
        int given;

        repeat (3) @(negedge clk);
        check_val("rst_valid", tx_wr_valid, 0);
        check_val("rst_re", output_fifo_re, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_addr", tx_wr_addr, 0);
        check_val("rst_data", tx_wr_data, 0);
        reset = 1'b0;

        // zero-length context
        n0 = n_req;
        start_ctx(0, 32'h500);
        #1;
        check_val("len0_done", done, 1);
        check_val("len0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check_val("len0_busy_later", busy, 0);
        check_val("len0_no_req", n_req - n0, 0);

        // basic 4-line context, responses 5 cycles after each request
        n0 = n_req;
        load_ctx(4, 32'h1000);
        start_ctx(4, 32'h1000);
        #1;
        check_val("t1_busy", busy, 1);
        check_val("t1_done_clr", done, 0);
        wait_done("t1", 100, dc);
        check_val("t1_nreq", n_req - n0, 4);
        check_val("t1_consec", req_cyc[n0 + 3] - req_cyc[n0], 3);
        check_val("t1_done_lat", dc - last_rx_cyc, 1);
        check_val("t1_busy_end", busy, 0);

        // almostfull held high for cycles 2..6 after start
        n0 = n_req;
        load_ctx(8, 32'h2000);
        start_ctx(8, 32'h2000);
        for (int k = 1; k < 200; k++) begin
            tx_wr_almostfull = (k >= 2) && (k <= 6);
            #1;
            if (tx_wr_almostfull) check_val("t3_re_while_af", output_fifo_re, 0);
            if (done) break;
            @(negedge clk);
        end
        tx_wr_almostfull = 1'b0;
        check_val("t3_done", done, 1);
        check_val("t3_nreq", n_req - n0, 8);

        // address wrap
        load_ctx(3, 32'hFFFF_FFFE);
        start_ctx(3, 32'hFFFF_FFFE);
        wait_done("t5", 100, dc);

        // outstanding limit with responses withheld
        auto_resp = 1'b0;
        n0 = n_req;
        load_ctx(10, 32'h4000);
        start_ctx(10, 32'h4000);
        repeat (12) @(negedge clk);
        #1;
        check_val("t4_stall_at_max", n_req - n0, 4);
        check_val("t4_re_blocked", output_fifo_re, 0);
        rx_manual = 1'b1;
        @(negedge clk);
        rx_manual = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_val("t4_one_more", n_req - n0, 5);
        given = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (done) break;
            rx_manual = (given < (n_req - n0));
            if (rx_manual) given++;
        end
        rx_manual = 1'b0;
        auto_resp = 1'b1;
        check_val("t4_done", done, 1);
        check_val("t4_responses", given, 10);

        // reset mid-context after the 2nd of 6 writes
        load_ctx(2, 32'h6000);
        start_ctx(6, 32'h6000);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (tx_wr_valid && (tx_wr_tag == TW'(1))) break;
        end
        check_val("t6_second_req", tx_wr_valid && (tx_wr_tag == TW'(1)), 1);
        reset = 1'b1;
        #1;
        check_val("t6_valid_drop", tx_wr_valid, 0);
        check_val("t6_busy_drop", busy, 0);
        check_val("t6_addr_drop", tx_wr_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t6_idle_done", done, 0);
        n0 = n_req;
        load_ctx(2, 32'h7000);
        start_ctx(2, 32'h7000);
        wait_done("t6", 100, dc);
        check_val("t6_nreq", n_req - n0, 2);
        check_val("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
